// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU op codes and the PC / writeback / ALU operand select values.
package multicycle_control_fsm_pkg;

  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_EX_R    = 4'd2;
  localparam logic [3:0] S_EX_I    = 4'd3;
  localparam logic [3:0] S_EX_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_LD  = 4'd5;
  localparam logic [3:0] S_MEM_ST  = 4'd6;
  localparam logic [3:0] S_WB_ALU  = 4'd7;
  localparam logic [3:0] S_WB_LD   = 4'd8;
  localparam logic [3:0] S_EX_BR   = 4'd9;
  localparam logic [3:0] S_EX_JAL  = 4'd10;
  localparam logic [3:0] S_EX_JALR = 4'd11;
  localparam logic [3:0] S_NOP     = 4'd12;
  localparam logic [3:0] S_HALT    = 4'd13;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_BR    = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_ALU    = 2'b01;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b10;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SEL_MDR    = 2'b01;
  localparam logic [1:0] WB_SEL_PC4    = 2'b10;

  localparam logic [1:0] ALU_B_RS2 = 2'b00;
  localparam logic [1:0] ALU_B_IMM = 2'b10;

  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM: opcode_known = 1'b1;
      default:                               opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_perf_counter.sv
// Free-running cycle and retired-instruction counters with per-counter enables;
// holding both enables low freezes the counts. Wraps modulo 2^CNT_W.
module ctrl_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cycle_en,
  input  logic             instret_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (cycle_en)   cycle_count   <= cycle_count + 1'b1;
      if (instret_en) instret_count <= instret_count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core (IF/ID/EX/MEM/WB sequencing).
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic             alu_bcond,
  input  logic             is_halt,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       wb_sel,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal_inst
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`endif
);

  logic [3:0] state, next_state;
  logic       pc_write_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_write_c, alu_src_a_c, halted_c, id_illegal;
  logic [1:0] pc_source_c, wb_sel_c, alu_src_b_c, alu_op_c;

  assign id_illegal = HALT_ON_ILLEGAL && !opcode_known(opcode);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IF;
      illegal_inst <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_ID && id_illegal) illegal_inst <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_write_c  = 1'b0;
    pc_source_c = PC_SRC_PC4;
    i_or_d_c    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    wb_sel_c    = WB_SEL_ALUOUT;
    reg_write_c = 1'b0;
    alu_src_a_c = 1'b0;
    alu_src_b_c = ALU_B_RS2;
    alu_op_c    = ALU_OP_ADD;
    halted_c    = 1'b0;
    case (state)
      S_IF: begin
        mem_read_c = 1'b1;
        ir_write_c = mem_ready;
        if (mem_ready) next_state = S_ID;
      end
      // ID precomputes the branch target into ALUOut while decoding
      S_ID: begin
        alu_src_b_c = ALU_B_IMM;
        case (opcode)
          OP_RTYPE:  next_state = S_EX_R;
          OP_ITYPE:  next_state = S_EX_I;
          OP_LOAD,
          OP_STORE:  next_state = S_EX_ADDR;
          OP_BRANCH: next_state = S_EX_BR;
          OP_JAL:    next_state = S_EX_JAL;
          OP_JALR:   next_state = S_EX_JALR;
          OP_SYSTEM: next_state = is_halt ? S_HALT : S_NOP;
          default:   next_state = id_illegal ? S_HALT : S_NOP;
        endcase
      end
      S_EX_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_OP_RTYPE;
        next_state  = S_WB_ALU;
      end
      S_EX_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = ALU_B_IMM;
        alu_op_c    = ALU_OP_ITYPE;
        next_state  = S_WB_ALU;
      end
      S_EX_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = ALU_B_IMM;
        next_state  = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
      end
      S_MEM_LD: begin
        i_or_d_c   = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready) next_state = S_WB_LD;
      end
      // a store retires in the same cycle its write is accepted
      S_MEM_ST: begin
        i_or_d_c    = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          pc_write_c = 1'b1;
          next_state = S_IF;
        end
      end
      S_WB_ALU, S_WB_LD: begin
        reg_write_c = 1'b1;
        wb_sel_c    = (state == S_WB_LD) ? WB_SEL_MDR : WB_SEL_ALUOUT;
        pc_write_c  = 1'b1;
        next_state  = S_IF;
      end
      S_EX_BR: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_OP_BR;
        pc_write_c  = 1'b1;
        pc_source_c = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
        next_state  = S_IF;
      end
      S_EX_JAL: begin
        reg_write_c = 1'b1;
        wb_sel_c    = WB_SEL_PC4;
        pc_write_c  = 1'b1;
        pc_source_c = PC_SRC_ALUOUT;
        next_state  = S_IF;
      end
      // the datapath clears bit 0 of the ALU result for the jump target
      S_EX_JALR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = ALU_B_IMM;
        reg_write_c = 1'b1;
        wb_sel_c    = WB_SEL_PC4;
        pc_write_c  = 1'b1;
        pc_source_c = PC_SRC_ALU;
        next_state  = S_IF;
      end
      S_NOP: begin
        pc_write_c = 1'b1;
        next_state = S_IF;
      end
      S_HALT:  halted_c   = 1'b1;
      default: next_state = S_IF;
    endcase
  end

  // Reset masks every strobe immediately, so an aborted access never completes.
  assign pc_write  = reset_n & pc_write_c;
  assign pc_source = reset_n ? pc_source_c : 2'b00;
  assign i_or_d    = reset_n & i_or_d_c;
  assign mem_read  = reset_n & mem_read_c;
  assign mem_write = reset_n & mem_write_c;
  assign ir_write  = reset_n & ir_write_c;
  assign wb_sel    = reset_n ? wb_sel_c : 2'b00;
  assign reg_write = reset_n & reg_write_c;
  assign alu_src_a = reset_n & alu_src_a_c;
  assign alu_src_b = reset_n ? alu_src_b_c : 2'b00;
  assign alu_op    = reset_n ? alu_op_c : 2'b00;
  assign halted    = reset_n & halted_c;

  // Counter width is only meaningful when positive.
  if (CNT_W < 1) begin : g_cnt_w_invalid
    logic cnt_w_invalid;
  end

`ifdef CTRL_PERF_CNT_EN
  ctrl_perf_counter #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .reset_n      (reset_n),
    .cycle_en     (state != S_HALT),
    .instret_en   (pc_write_c),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );
`endif

endmodule
